// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU widths, select type,
// arbiter FSM states and a small wrap-around increment helper.
package alu_pkg;

    localparam int ALU_W  = 4;
    localparam int ALU_SW = 3;

    typedef logic [ALU_SW-1:0] alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Next round-robin position after idx, wrapping back to 0 at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: the first set request bit at or above
// ptr wins, searching upward with wrap-around. The request vector is
// rotated so ptr lands on bit 0, the lowest set bit is isolated, and the
// one-hot result is rotated back into place.
module rr_grant #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic            any
);

    logic [2*NREQ-1:0] dbl_req;
    logic [2*NREQ-1:0] dbl_gnt;
    logic [NREQ-1:0]   rot_req;
    logic [NREQ-1:0]   rot_gnt;

    // Rotate, isolate lowest set bit, rotate back.
    always_comb begin
        dbl_req = {req, req} >> ptr;
        rot_req = dbl_req[NREQ-1:0];
        rot_gnt = rot_req & (~rot_req + NREQ'(1));
        dbl_gnt = {rot_gnt, rot_gnt} << ptr;
        gnt     = dbl_gnt[2*NREQ-1:NREQ];
        any     = |req;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4-bit ALU between NREQ
// requesters. One operation at a time: accept (IDLE), execute with
// registered operands (EXEC), then hold the registered result until the
// granted requester takes it (RESP).
// Optional feature macro: ALU_ARB_PRIO0_EN gives requester 0 absolute
// priority in IDLE without advancing the round-robin pointer.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ALU_W-1:0] req_a,
    input  logic [NREQ*ALU_W-1:0] req_b,
    input  logic [NREQ*ALU_SW-1:0] req_s,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [ALU_W-1:0]      rsp_y,
    output logic [ALU_W-1:0]      alu_a,
    output logic [ALU_W-1:0]      alu_b,
    output logic [ALU_SW-1:0]     alu_s,
    input  logic [ALU_W-1:0]      alu_y
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gnt;

    logic [NREQ-1:0]  rr_gnt;
    logic             rr_any;
    logic [NREQ-1:0]  pick_onehot;
    logic             pick_prio;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    next_ptr;
    logic [ALU_W-1:0] pick_a;
    logic [ALU_W-1:0] pick_b;
    alu_op_t          pick_s;

    rr_grant #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_grant (
        .req  (req_valid),
        .ptr  (ptr),
        .gnt  (rr_gnt),
        .any  (rr_any)
    );

`ifdef ALU_ARB_PRIO0_EN
    // Requester 0 overrides the round-robin choice whenever it is valid.
    always_comb begin
        pick_prio   = req_valid[0];
        pick_onehot = req_valid[0] ? NREQ'(1) : rr_gnt;
    end
`else
    // Pure round-robin: the picker's choice is final.
    always_comb begin
        pick_prio   = 1'b0;
        pick_onehot = rr_gnt;
    end
`endif

    // Convert the one-hot winner into an index and select its operands.
    always_comb begin
        pick_idx = '0;
        pick_a   = '0;
        pick_b   = '0;
        pick_s   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_onehot[i]) begin
                pick_idx = PW'(i);
                pick_a   = req_a[ALU_W*i +: ALU_W];
                pick_b   = req_b[ALU_W*i +: ALU_W];
                pick_s   = req_s[ALU_SW*i +: ALU_SW];
            end
        end
        next_ptr = PW'(wrap_inc(int'(pick_idx), NREQ));
    end

    // Accept is offered only while idle; held low during reset so every
    // output reads zero while rst is asserted.
    assign req_ready = (state == IDLE && !rst) ? pick_onehot : '0;

    // Arbiter FSM with registered ALU operands and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_s     <= '0;
            rsp_valid <= '0;
            rsp_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rr_any) begin
                        alu_a <= pick_a;
                        alu_b <= pick_b;
                        alu_s <= pick_s;
                        gnt   <= pick_idx;
                        if (!pick_prio) begin
                            ptr <= next_ptr;
                        end
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y     <= alu_y;
                    rsp_valid <= NREQ'(1) << gnt;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // At most one requester is offered an accept or a response at a time.
    a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
    a_rsp_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 4-bit ALU attached to
// the operand/result ports. Covers reset, a table of single operations
// including a back-to-back select sweep, fairness, response backpressure,
// reset during execute, and requester-0 priority (ALU_ARB_PRIO0_EN) or
// plain round-robin alternation in the default build.
module tb_alu_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*4-1:0] req_a;
    logic [NREQ*4-1:0] req_b;
    logic [NREQ*3-1:0] req_s;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [3:0]        rsp_y;
    logic [3:0]        alu_a;
    logic [3:0]        alu_b;
    logic [2:0]        alu_s;
    logic [3:0]        alu_y;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         r;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] s;
        logic [3:0] y;
    } vec_t;

    vec_t vecs[9];

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_s     (req_s),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_y     (alu_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the external ALU.
    function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        case (s)
            3'b000: return a + b;
            3'b001: return a - b;
            3'b010: return a & b;
            3'b011: return a | b;
            3'b100: return a ^ b;
            3'b101: return ~a;
            3'b110: return a << 1;
            default: return a >> 1;
        endcase
    endfunction

    assign alu_y = alu_model(alu_a, alu_b, alu_s);

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int r, input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        req_valid          = '0;
        req_valid[r]       = 1'b1;
        req_a[4*r +: 4]    = a;
        req_b[4*r +: 4]    = b;
        req_s[3*r +: 3]    = s;
        #1;
    endtask

    // Wait (bounded) for an accept, then follow the operation to its response.
    // Returns at the negedge of the cycle in which rsp_valid is first high.
    task automatic run_txn(input string name, input logic [3:0] exp_gnt,
                           input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                           input logic [3:0] y, output int acc_cyc);
        int waited;
        waited = 0;
        while (req_ready === 4'b0000 && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        acc_cyc = cyc;
        if (req_ready === 4'b0000) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: actual req_ready 0000 required %b", name, exp_gnt);
            return;
        end
        check_output({name, "_req_ready"}, 8'(req_ready), 8'(exp_gnt));
        @(negedge clk);
        check_output({name, "_alu_a"}, 8'(alu_a), 8'(a));
        check_output({name, "_alu_b"}, 8'(alu_b), 8'(b));
        check_output({name, "_alu_s"}, 8'(alu_s), 8'(s));
        check_output({name, "_exec_rsp_valid"}, 8'(rsp_valid), 8'h00);
        check_output({name, "_exec_req_ready"}, 8'(req_ready), 8'h00);
        @(negedge clk);
        check_output({name, "_rsp_valid"}, 8'(rsp_valid), 8'(exp_gnt));
        check_output({name, "_rsp_y"}, 8'(rsp_y), 8'(y));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int last;
        logic [3:0] exp_seq[3];

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_s     = '0;
        rsp_ready = '0;

        repeat (2) @(negedge clk);
        check_output("reset_req_ready", 8'(req_ready), 8'h00);
        check_output("reset_rsp_valid", 8'(rsp_valid), 8'h00);
        check_output("reset_rsp_y",     8'(rsp_y),     8'h00);
        check_output("reset_alu_a",     8'(alu_a),     8'h00);
        check_output("reset_alu_b",     8'(alu_b),     8'h00);
        check_output("reset_alu_s",     8'(alu_s),     8'h00);
        rst       = 1'b0;
        rsp_ready = 4'b1111;

        // Single request from 0, then requester 2 sweeps all selects with a=6, b=3.
        vecs[0] = '{0, 4'b1001, 4'b1010, 3'b000, 4'b0011};
        vecs[1] = '{2, 4'b0110, 4'b0011, 3'b000, 4'b1001};
        vecs[2] = '{2, 4'b0110, 4'b0011, 3'b001, 4'b0011};
        vecs[3] = '{2, 4'b0110, 4'b0011, 3'b010, 4'b0010};
        vecs[4] = '{2, 4'b0110, 4'b0011, 3'b011, 4'b0111};
        vecs[5] = '{2, 4'b0110, 4'b0011, 3'b100, 4'b0101};
        vecs[6] = '{2, 4'b0110, 4'b0011, 3'b101, 4'b1001};
        vecs[7] = '{2, 4'b0110, 4'b0011, 3'b110, 4'b1100};
        vecs[8] = '{2, 4'b0110, 4'b0011, 3'b111, 4'b0011};

        last = 0;
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].s);
            run_txn($sformatf("vec%0d", i), 4'(1 << vecs[i].r),
                    vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].y, acc);
            if (i > 0) begin
                check_output($sformatf("vec%0d_interval", i), 8'(acc - last), 8'd3);
            end
            last = acc;
        end

        // Fairness from a fresh pointer: requester i computes (i+1)+2.
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst       = 1'b0;
        req_a     = {4'd4, 4'd3, 4'd2, 4'd1};
        req_b     = {4'd2, 4'd2, 4'd2, 4'd2};
        req_s     = '0;
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 6; k++) begin
            run_txn($sformatf("fair%0d", k), 4'(1 << (k % 4)),
                    4'((k % 4) + 1), 4'd2, 3'b000, 4'((k % 4) + 3), acc);
        end

        // Response backpressure on requester 1 (pointer now at 2).
        @(negedge clk);
        rsp_ready = 4'b1101;
        apply_stimulus(1, 4'b0101, 4'b0110, 3'b011);
        run_txn("bp", 4'b0010, 4'b0101, 4'b0110, 3'b011, 4'b0111, acc);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_output($sformatf("bp_hold%0d_rsp_valid", k), 8'(rsp_valid), 8'h02);
            check_output($sformatf("bp_hold%0d_rsp_y", k),     8'(rsp_y),     8'h07);
            check_output($sformatf("bp_hold%0d_req_ready", k), 8'(req_ready), 8'h00);
        end
        rsp_ready = 4'b1111;
        @(negedge clk);
        check_output("bp_release_rsp_valid", 8'(rsp_valid), 8'h00);
        check_output("bp_release_req_ready", 8'(req_ready), 8'h04);

        // Requester 2 is accepted at the next edge; reset it while in EXEC.
        @(negedge clk);
        check_output("rst_exec_alu_a", 8'(alu_a), 8'h03);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check_output("rst_exec_req_ready", 8'(req_ready), 8'h00);
        check_output("rst_exec_rsp_valid", 8'(rsp_valid), 8'h00);
        check_output("rst_exec_rsp_y",     8'(rsp_y),     8'h00);
        check_output("rst_exec_alu_a",     8'(alu_a),     8'h00);
        check_output("rst_exec_alu_b",     8'(alu_b),     8'h00);
        check_output("rst_exec_alu_s",     8'(alu_s),     8'h00);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output($sformatf("rst_quiet%0d_rsp_valid", k), 8'(rsp_valid), 8'h00);
        end
        req_valid = 4'b1111;
        #1;
        run_txn("post_rst", 4'b0001, 4'd1, 4'd2, 3'b000, 4'd3, acc);

        // Requesters 0 and 3 continuously valid, then 0 drops out.
`ifdef ALU_ARB_PRIO0_EN
        exp_seq[0] = 4'b0001;
        exp_seq[1] = 4'b0001;
        exp_seq[2] = 4'b0001;
`else
        exp_seq[0] = 4'b1000;
        exp_seq[1] = 4'b0001;
        exp_seq[2] = 4'b1000;
`endif
        req_valid = 4'b1001;
        #1;
        for (int k = 0; k < 3; k++) begin
            run_txn($sformatf("pair%0d", k), exp_seq[k], exp_seq[k][0] ? 4'd1 : 4'd4,
                    4'd2, 3'b000, exp_seq[k][0] ? 4'd3 : 4'd6, acc);
        end
        req_valid = 4'b1000;
        #1;
        run_txn("only3", 4'b1000, 4'd4, 4'd2, 3'b000, 4'd6, acc);

        req_valid = '0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single 4-bit `ALU` (operands `a`, `b`; select `s`; result `y`) between `NREQ` requesters. It accepts one operation at a time over a valid/ready handshake and drives registered operands into the ALU. It captures the ALU result and returns it to the granted requester over a second valid/ready handshake. It sits between the requesting engines and the `ALU` instance.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in NREQ: per-requester operation valid
- `req_ready` out NREQ: one-hot accept, combinational
- `req_a` in NREQ*4: operand A, slice i = `[4i+3:4i]`
- `req_b` in NREQ*4: operand B, same slicing
- `req_s` in NREQ*3: ALU select, slice i = `[3i+2:3i]`
- `rsp_valid` out NREQ: one-hot result valid, registered
- `rsp_ready` in NREQ: per-requester result accept
- `rsp_y` out 4: result, registered
- `alu_a`, `alu_b` out 4: registered operands to `ALU.a`/`ALU.b`
- `alu_s` out 3: registered select to `ALU.s`
- `alu_y` in 4: from `ALU.y`, combinational

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE**
  - If no `req_valid` bit is set, stay in IDLE and drive all `req_ready` low.
  - Otherwise pick the winner: search from `ptr` upward with wrap-around, first valid wins.
  - Assert `req_ready[winner]` in the same cycle.
  - At the clock edge, register `alu_a`/`alu_b`/`alu_s` from the winner's slices, store `gnt` = winner, set `ptr` = (winner+1) mod NREQ, and go to EXEC.
- **EXEC**
  - Operands are held stable.
  - At the edge, `rsp_y` <= `alu_y` and `rsp_valid[gnt]` <= 1, then go to RESP.
- **RESP**
  - Hold `rsp_valid[gnt]` and `rsp_y` until `rsp_ready[gnt]` is sampled high.
  - At that edge, clear `rsp_valid` and go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- `req_ready` is low in EXEC and RESP.
- Requesters must hold `req_valid` and their operands stable until accepted. Dropping `req_valid` early is a protocol violation with undefined outcome.
- `alu_a`/`alu_b`/`alu_s` retain the last accepted operation in every state.
- **Reset**
  - Clears `ptr` to 0, `gnt` to 0, all outputs to 0, and the state to IDLE.
  - Reset asserted mid-operation discards the in-flight operation; no response is issued.

## Timing
- Accept at edge T (`req_valid & req_ready`).
- ALU inputs are valid during cycle T+1.
- `rsp_valid` is high from cycle T+2.
- Minimum turnaround is 3 cycles per operation: accept, execute, response with `rsp_ready` already high.
- The next accept occurs no earlier than the cycle after the response handshake.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NREQ-1,0.

## Configuration
- `ALU_ARB_PRIO0_EN` defined:
  - Requester 0 wins whenever `req_valid[0]` is high in IDLE.
  - A grant to requester 0 leaves `ptr` unchanged.
  - Other requesters use round-robin as above.
- `ALU_ARB_PRIO0_EN` undefined: pure round-robin for all requesters.

## Structure
- Shared package `alu_pkg`:
  - `ALU_W`=4 and `ALU_SW`=3
  - `alu_op_t` (3-bit select typedef)
  - `arb_state_t` enum (IDLE, EXEC, RESP)
- Sub-module `rr_grant`: combinational round-robin picker.
  - Inputs: `req` and `ptr`.
  - Outputs: one-hot `gnt` and `any`.
- The `ALU` instance sits outside this block, at the parent level.

## Test plan
- **Single request:** `req_valid[0]`=1, `req_a[3:0]`=4'b1001, `req_b[3:0]`=4'b1010, `req_s[2:0]`=3'b000.
  - `req_ready[0]`=1 in the same cycle.
  - `alu_a`=1001, `alu_b`=1010, `alu_s`=000 at T+1.
  - `rsp_valid`=4'b0001 and `rsp_y` equal to the ALU model result at T+2.
- **Select sweep:** requester 2 issues `s`=000..111 back-to-back with the same operands and `rsp_ready` tied high.
  - 8 responses, each 3 cycles apart.
  - Each `rsp_y` matches the ALU model.
  - Only `rsp_valid[2]` is ever set.
- **Fairness:** all four requesters continuously valid.
  - Grant order is 0,1,2,3,0,1.
  - `ptr` wraps from 3 to 0.
- **Response backpressure:** hold `rsp_ready[1]`=0 for 5 cycles after `rsp_valid[1]` rises.
  - `rsp_y` stays stable.
  - No `req_ready` is asserted until `rsp_ready[1]`=1.
- **Reset in EXEC:** assert `rst` one cycle after an accept.
  - No response is issued.
  - All outputs are 0.
  - The next grant goes to requester 0.
- **With `ALU_ARB_PRIO0_EN` defined:** requesters 0 and 3 are continuously valid.
  - Requester 0 wins every grant.
  - Once requester 0 drops its request, requester 3 is granted.
